// File: rtl/mem_stage_bus.sv
// Memory stage with a req/ack bus master and the MEM/WB output register.
// Misaligned accesses and timed-out accesses both leave a bubble in MEM/WB.
module mem_stage_bus #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int BASE_ADDR = 1024,
  parameter int TIMEOUT   = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wb_en_in,
  input  logic                mem_r_en_in,
  input  logic                mem_w_en_in,
  input  logic [DATA_W-1:0]   alu_res_in,
  input  logic [DATA_W-1:0]   val_rm,
  input  logic [3:0]          dest_in,
  input  logic [1:0]          size_in,
  input  logic                sign_in,
  output logic                freeze,
  output logic                valid_out,
  output logic                wb_en_out,
  output logic                mem_r_en_out,
  output logic [DATA_W-1:0]   alu_res_out,
  output logic [3:0]          dest_out,
  output logic [DATA_W-1:0]   mem_result,
  output logic                align_err,
  output logic                bus_err,
  output logic                bus_req,
  output logic                bus_we,
  output logic [ADDR_W-1:0]   bus_addr,
  output logic [DATA_W-1:0]   bus_wdata,
  output logic [DATA_W/8-1:0] bus_be,
  input  logic [DATA_W-1:0]   bus_rdata,
  input  logic                bus_ack
);

  localparam int BE_W   = DATA_W / 8;
  localparam int LANE_W = $clog2(BE_W);
  localparam int CNT_W  = $clog2(TIMEOUT);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                valid_q, valid_d;
  logic                wb_en_q, wb_en_d;
  logic                mem_r_q, mem_r_d;
  logic [DATA_W-1:0]   alu_q, alu_d;
  logic [3:0]          dest_q, dest_d;
  logic [DATA_W-1:0]   result_q, result_d;
  logic                align_err_q, align_err_d;
  logic                bus_err_q, bus_err_d;
  logic                req_q, req_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [BE_W-1:0]     be_q, be_d;

  logic                mem_op, is_load, size_word, misaligned, timeout_hit;
  logic [ADDR_W-1:0]   offset;
  logic [LANE_W-1:0]   lane;
  logic [DATA_W-1:0]   rdata_shifted;

  function automatic logic [BE_W-1:0] be_pattern(input logic [1:0] size,
                                                  input logic [LANE_W-1:0] ln);
    logic [BE_W-1:0] pat;
    case (size)
      2'b10:   pat = BE_W'(1);
      2'b01:   pat = BE_W'(3);
      default: pat = BE_W'(15);
    endcase
    return pat << ln;
  endfunction

  function automatic logic [DATA_W-1:0] store_data(input logic [1:0] size,
                                                   input logic [DATA_W-1:0] val);
    case (size)
      2'b10:   return {BE_W{val[7:0]}};
      2'b01:   return {(DATA_W/16){val[15:0]}};
      default: return val;
    endcase
  endfunction

  // Mask off the access width, then fill the upper bits with the sign if asked.
  function automatic logic [DATA_W-1:0] load_extend(input logic [DATA_W-1:0] raw,
                                                    input logic [1:0] size,
                                                    input logic sx);
    logic [DATA_W-1:0] mask;
    logic              msb;
    logic [DATA_W-1:0] ext;
    case (size)
      2'b10: begin
        mask = {DATA_W{1'b1}} >> (DATA_W - 8);
        msb  = raw[7];
      end
      2'b01: begin
        mask = {DATA_W{1'b1}} >> (DATA_W - 16);
        msb  = raw[15];
      end
      default: begin
        mask = {DATA_W{1'b1}} >> (DATA_W - 32);
        msb  = raw[31];
      end
    endcase
    ext = raw & mask;
    if (sx && msb) ext = ext | ~mask;
    return ext;
  endfunction

  assign mem_op        = mem_r_en_in | mem_w_en_in;
  assign is_load       = mem_r_en_in & ~mem_w_en_in;
  assign offset        = ADDR_W'(alu_res_in) - ADDR_W'(BASE_ADDR);
  assign lane          = offset[LANE_W-1:0];
  assign size_word     = (size_in == 2'b00) || (size_in == 2'b11);
  assign misaligned    = mem_op && ((size_word && (lane[1:0] != 2'b00)) ||
                                    ((size_in == 2'b01) && lane[0]));
  assign timeout_hit   = (state_q == BUSY) && !bus_ack && (cnt_q == CNT_W'(TIMEOUT - 1));
  assign rdata_shifted = bus_rdata >> {lane, 3'b000};

  assign freeze = (state_q == IDLE) ? (mem_op & ~misaligned) : (~bus_ack & ~timeout_hit);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    valid_d     = 1'b0;
    wb_en_d     = 1'b0;
    mem_r_d     = 1'b0;
    alu_d       = '0;
    dest_d      = '0;
    result_d    = '0;
    align_err_d = 1'b0;
    bus_err_d   = 1'b0;
    req_d       = req_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    be_d        = be_q;
    case (state_q)
      IDLE: begin
        if (!mem_op) begin
          valid_d = 1'b1;
          wb_en_d = wb_en_in;
          alu_d   = alu_res_in;
          dest_d  = dest_in;
        end else if (misaligned) begin
          align_err_d = 1'b1;
        end else begin
          state_d = BUSY;
          cnt_d   = '0;
          req_d   = 1'b1;
          we_d    = mem_w_en_in;
          addr_d  = {offset[ADDR_W-1:LANE_W], {LANE_W{1'b0}}};
          wdata_d = store_data(size_in, val_rm);
          be_d    = be_pattern(size_in, lane);
        end
      end
      BUSY: begin
        if (bus_ack || timeout_hit) begin
          state_d = IDLE;
          cnt_d   = '0;
          req_d   = 1'b0;
          we_d    = 1'b0;
          addr_d  = '0;
          wdata_d = '0;
          be_d    = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
        // Ack takes priority over a timeout landing in the same cycle.
        if (bus_ack) begin
          valid_d  = 1'b1;
          wb_en_d  = wb_en_in;
          mem_r_d  = is_load;
          alu_d    = alu_res_in;
          dest_d   = dest_in;
          result_d = is_load ? load_extend(rdata_shifted, size_in, sign_in) : '0;
        end else if (timeout_hit) begin
          bus_err_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      valid_q     <= 1'b0;
      wb_en_q     <= 1'b0;
      mem_r_q     <= 1'b0;
      alu_q       <= '0;
      dest_q      <= '0;
      result_q    <= '0;
      align_err_q <= 1'b0;
      bus_err_q   <= 1'b0;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      valid_q     <= valid_d;
      wb_en_q     <= wb_en_d;
      mem_r_q     <= mem_r_d;
      alu_q       <= alu_d;
      dest_q      <= dest_d;
      result_q    <= result_d;
      align_err_q <= align_err_d;
      bus_err_q   <= bus_err_d;
      req_q       <= req_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      be_q        <= be_d;
    end
  end

  assign valid_out    = valid_q;
  assign wb_en_out    = wb_en_q;
  assign mem_r_en_out = mem_r_q;
  assign alu_res_out  = alu_q;
  assign dest_out     = dest_q;
  assign mem_result   = result_q;
  assign align_err    = align_err_q;
  assign bus_err      = bus_err_q;
  assign bus_req      = req_q;
  assign bus_we       = we_q;
  assign bus_addr     = addr_q;
  assign bus_wdata    = wdata_q;
  assign bus_be       = be_q;

endmodule

// File: tb/tb_mem_stage_bus.sv
// Bench for mem_stage_bus: vector table with a bus responder and a
// scoreboard of expected MEM/WB records checked whenever valid_out is high.
module tb_mem_stage_bus;

  localparam int DATA_W  = 32;
  localparam int ADDR_W  = 32;
  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_en_in, mem_r_en_in, mem_w_en_in, sign_in;
  logic [31:0] alu_res_in, val_rm, bus_rdata;
  logic [3:0]  dest_in;
  logic [1:0]  size_in;
  logic        bus_ack;
  logic        freeze, valid_out, wb_en_out, mem_r_en_out, align_err, bus_err;
  logic        bus_req, bus_we;
  logic [31:0] alu_res_out, mem_result, bus_addr, bus_wdata;
  logic [3:0]  dest_out, bus_be;

  mem_stage_bus #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BASE_ADDR(1024), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .wb_en_in(wb_en_in), .mem_r_en_in(mem_r_en_in),
    .mem_w_en_in(mem_w_en_in), .alu_res_in(alu_res_in), .val_rm(val_rm),
    .dest_in(dest_in), .size_in(size_in), .sign_in(sign_in), .freeze(freeze),
    .valid_out(valid_out), .wb_en_out(wb_en_out), .mem_r_en_out(mem_r_en_out),
    .alu_res_out(alu_res_out), .dest_out(dest_out), .mem_result(mem_result),
    .align_err(align_err), .bus_err(bus_err), .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_be(bus_be),
    .bus_rdata(bus_rdata), .bus_ack(bus_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wb, r, w;
    logic [31:0] alu, val;
    logic [3:0]  dest;
    logic [1:0]  size;
    logic        sign;
    logic [31:0] rdata;
    int          ack_at;   // BUSY cycle that sees ack; 0 = never
    logic        e_align;
    logic [31:0] e_addr;
    logic [3:0]  e_be;
    logic [31:0] e_wdata;
    logic [31:0] e_res;
  } vec_t;

  typedef struct {
    logic        wb, memr;
    logic [31:0] alu, res;
    logic [3:0]  dest;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(logic wb, logic r, logic w, logic [31:0] alu, logic [31:0] val,
                              logic [3:0] dest, logic [1:0] size, logic sign,
                              logic [31:0] rdata, int ack_at, logic e_align,
                              logic [31:0] e_addr, logic [3:0] e_be,
                              logic [31:0] e_wdata, logic [31:0] e_res);
    vec_t v;
    v.wb = wb; v.r = r; v.w = w; v.alu = alu; v.val = val; v.dest = dest;
    v.size = size; v.sign = sign; v.rdata = rdata; v.ack_at = ack_at;
    v.e_align = e_align; v.e_addr = e_addr; v.e_be = e_be;
    v.e_wdata = e_wdata; v.e_res = e_res;
    return v;
  endfunction

  always @(negedge clk) begin
    if (rst === 1'b1 && valid_out === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_valid", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("wb_en_out", wb_en_out, e.wb);
        chk("mem_r_en_out", mem_r_en_out, e.memr);
        chk("alu_res_out", alu_res_out, e.alu);
        chk("dest_out", dest_out, e.dest);
        chk("mem_result", mem_result, e.res);
      end
    end
  end

  task automatic drive(input vec_t v);
    wb_en_in = v.wb; mem_r_en_in = v.r; mem_w_en_in = v.w;
    alu_res_in = v.alu; val_rm = v.val; dest_in = v.dest;
    size_in = v.size; sign_in = v.sign;
  endtask

  // Called at posedge+1 with the DUT in IDLE; returns at posedge+1.
  task automatic run_op(input vec_t v);
    exp_t e;
    int   busy, nfz, exp_busy;
    logic done;
    drive(v);
    e.wb = v.wb; e.memr = v.r & ~v.w; e.alu = v.alu; e.dest = v.dest; e.res = v.e_res;
    if (!(v.r | v.w)) begin
      bus_ack = 1'b1;
      bus_rdata = 32'hFFFF_FFFF;
      sb.push_back(e);
      @(negedge clk);
      chk("nonmem_freeze", freeze, 0);
      chk("nonmem_req", bus_req, 0);
      @(posedge clk); #1;
      bus_ack = 1'b0;
    end else if (v.e_align) begin
      @(negedge clk);
      chk("align_freeze", freeze, 0);
      @(posedge clk); #1;
      chk("align_err", align_err, 1);
      chk("align_req", bus_req, 0);
      chk("align_bubble", {valid_out, wb_en_out}, 0);
    end else begin
      if (v.ack_at != 0) sb.push_back(e);
      exp_busy = (v.ack_at == 0) ? TIMEOUT : v.ack_at;
      busy = 0; nfz = 0; done = 1'b0;
      for (int c = 0; c < 40 && !done; c++) begin
        @(negedge clk);
        if (bus_req) begin
          busy++;
          chk("bus_we", bus_we, v.w);
          chk("bus_addr", bus_addr, v.e_addr);
          chk("bus_be", bus_be, v.e_be);
          chk("bus_wdata", bus_wdata, v.e_wdata);
          if (v.ack_at != 0 && busy == v.ack_at) begin
            bus_ack = 1'b1;
            bus_rdata = v.rdata;
          end
        end
        #1;
        if (freeze) nfz++;
        @(posedge clk); #1;
        bus_ack = 1'b0;
        bus_rdata = $urandom;
        if (busy > 0 && !bus_req) done = 1'b1;
      end
      chk("op_completed", done, 1);
      chk("busy_cycles", busy, exp_busy);
      chk("freeze_cycles", nfz, exp_busy);
      chk("bus_err", bus_err, v.ack_at == 0);
    end
  endtask

  vec_t vecs[16];

  initial begin
    vecs[0]  = mk(1,0,0, 32'h55,        0,            3, 2'b00,0, 0,            0, 0, 0,            4'h0, 0,            0);
    vecs[1]  = mk(1,1,0, 1028,          0,            5, 2'b00,0, 32'hDEADBEEF, 4, 0, 4,            4'hF, 0,            32'hDEADBEEF);
    vecs[2]  = mk(0,0,1, 1026,          32'h123456A7, 0, 2'b10,0, 0,            1, 0, 0,            4'b0100, 32'hA7A7A7A7, 0);
    vecs[3]  = mk(1,1,0, 1030,          0,            6, 2'b01,1, 32'h80010000, 2, 0, 4,            4'hC, 0,            32'hFFFF8001);
    vecs[4]  = mk(1,1,0, 1030,          0,            6, 2'b01,0, 32'h80010000, 1, 0, 4,            4'hC, 0,            32'h00008001);
    vecs[5]  = mk(1,1,0, 1025,          0,            7, 2'b00,0, 0,            0, 1, 0,            4'h0, 0,            0);
    vecs[6]  = mk(1,1,0, 1032,          0,            8, 2'b00,0, 0,            0, 0, 8,            4'hF, 0,            0);
    vecs[7]  = mk(1,1,1, 1036,          32'hCAFEF00D, 9, 2'b00,0, 32'h11111111, 1, 0, 12,           4'hF, 32'hCAFEF00D, 0);
    vecs[8]  = mk(1,1,0, 1027,          0,           10, 2'b10,1, 32'h85000000, 3, 0, 0,            4'h8, 0,            32'hFFFFFF85);
    vecs[9]  = mk(0,0,1, 1026,          32'h123456A7, 0, 2'b01,0, 0,            2, 0, 0,            4'hC, 32'h56A756A7, 0);
    vecs[10] = mk(1,1,0, 1040,          0,           11, 2'b00,0, 32'h0BADF00D,16, 0, 16,           4'hF, 0,            32'h0BADF00D);
    vecs[11] = mk(1,1,0, 1024,          32'h77,      12, 2'b11,1, 32'h01234567, 1, 0, 0,            4'hF, 32'h77,       32'h01234567);
    vecs[12] = mk(1,1,0, 1025,          0,           13, 2'b01,0, 0,            0, 1, 0,            4'h0, 0,            0);
    vecs[13] = mk(1,1,0, 4,             0,           14, 2'b00,0, 32'h13572468, 1, 0, 32'hFFFFFC04, 4'hF, 0,            32'h13572468);
    vecs[14] = mk(0,0,0, 32'hFFFFFFFF,  0,           15, 2'b00,0, 0,            0, 0, 0,            4'h0, 0,            0);
    vecs[15] = mk(1,1,0, 1025,          0,            1, 2'b10,0, 32'h0000F000, 2, 0, 0,            4'b0010, 0,         32'h000000F0);

    rst = 1'b0; bus_ack = 1'b0; bus_rdata = '0;
    drive(mk(0,0,0,0,0,0,0,0,0,0,0,0,0,0,0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_regs", {valid_out, wb_en_out, mem_r_en_out, alu_res_out, dest_out,
                       mem_result, align_err, bus_err}, 0);
    chk("reset_bus", {bus_req, bus_we, bus_addr, bus_wdata, bus_be}, 0);
    @(posedge clk); #1;
    rst = 1'b1;

    foreach (vecs[i]) run_op(vecs[i]);

    // Asynchronous reset in the middle of an outstanding load.
    drive(vecs[1]);
    @(posedge clk); #1;
    chk("pre_reset_req", bus_req, 1);
    @(posedge clk); #1;
    @(posedge clk); #3;
    rst = 1'b0;
    #1;
    chk("async_rst_req", bus_req, 0);
    chk("async_rst_bus", {bus_we, bus_addr, bus_wdata, bus_be}, 0);
    chk("async_rst_regs", {valid_out, wb_en_out, mem_r_en_out, alu_res_out, dest_out,
                           mem_result, align_err, bus_err}, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    run_op(vecs[3]);
    run_op(vecs[0]);

    // Park on a misaligned access so no further instructions retire.
    drive(vecs[5]);
    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
